// File: rtl/inst_queue.sv
// inst_queue: circular instruction buffer between fetch and dual-issue decode.
// Accepts up to two fetched instructions per cycle and presents the two oldest
// entries as the inst0/inst1 f1 pair. It pops what the decoder captures and
// empties on a writeback flush.
// Optional macro IQ_BYPASS_EN: when the queue is empty, fetch slots drive the
// f1 outputs in the same cycle.
module inst_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_iq_i,
  input  logic        fetch_inst0_valid_i,
  input  logic        fetch_inst1_valid_i,
  input  logic [63:0] fetch_inst0_pc_i,
  input  logic [63:0] fetch_inst1_pc_i,
  input  logic [31:0] fetch_inst0_inst_i,
  input  logic [31:0] fetch_inst1_inst_i,
  output logic        fetch_ready_o,
  input  logic        stall_decoder_inst0_i,
  input  logic        stall_decoder_inst1_i,
  output logic        inst0_f1_valid_o,
  output logic        inst1_f1_valid_o,
  output logic [63:0] inst0_f1_pc_o,
  output logic [63:0] inst1_f1_pc_o,
  output logic [31:0] inst0_f1_inst_o,
  output logic [31:0] inst1_f1_inst_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic [63:0] pc_q   [DEPTH];
  logic [63:0] pc_d   [DEPTH];
  logic [31:0] inst_q [DEPTH];
  logic [31:0] inst_d [DEPTH];
  ptr_t        rd_ptr_q, rd_ptr_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  cnt_t        count_q, count_d;

  logic        accept;
  logic        q_valid0, q_valid1;
  ptr_t        rd_ptr_p1, wr_ptr_p1;
  logic [1:0]  pop_n, push_n;
  logic        c0_valid, c1_valid;
  logic [63:0] c0_pc;
  logic [31:0] c0_inst;

  // Output view, pop/push sizing and next-state for pointers, count and storage.
  // Fetch slots are compacted first so a lone slot1 lands at wr_ptr.
  always_comb begin
    rd_ptr_p1     = rd_ptr_q + ptr_t'(1);
    wr_ptr_p1     = wr_ptr_q + ptr_t'(1);
    q_valid0      = (count_q != '0);
    q_valid1      = (count_q >= cnt_t'(2));
    fetch_ready_o = (count_q <= cnt_t'(DEPTH - 2));
    accept        = !stall_decoder_inst0_i && !stall_decoder_inst1_i && !flush_iq_i;

    c0_valid = fetch_inst0_valid_i || fetch_inst1_valid_i;
    c1_valid = fetch_inst0_valid_i && fetch_inst1_valid_i;
    c0_pc    = fetch_inst0_valid_i ? fetch_inst0_pc_i   : fetch_inst1_pc_i;
    c0_inst  = fetch_inst0_valid_i ? fetch_inst0_inst_i : fetch_inst1_inst_i;

    inst0_f1_valid_o = q_valid0;
    inst1_f1_valid_o = q_valid1;
    inst0_f1_pc_o    = pc_q[rd_ptr_q];
    inst0_f1_inst_o  = inst_q[rd_ptr_q];
    inst1_f1_pc_o    = pc_q[rd_ptr_p1];
    inst1_f1_inst_o  = inst_q[rd_ptr_p1];

    pop_n  = accept ? ({1'b0, q_valid0} + {1'b0, q_valid1}) : 2'd0;
    push_n = fetch_ready_o ? ({1'b0, c0_valid} + {1'b0, c1_valid}) : 2'd0;

`ifdef IQ_BYPASS_EN
    // Empty queue: present fetch directly; consumed bypass entries are not stored.
    if ((count_q == '0) && !flush_iq_i) begin
      inst0_f1_valid_o = c0_valid;
      inst1_f1_valid_o = c1_valid;
      inst0_f1_pc_o    = c0_pc;
      inst0_f1_inst_o  = c0_inst;
      inst1_f1_pc_o    = fetch_inst1_pc_i;
      inst1_f1_inst_o  = fetch_inst1_inst_i;
      if (accept) begin
        push_n = 2'd0;
      end
    end
`endif

    pc_d   = pc_q;
    inst_d = inst_q;
    if (!flush_iq_i) begin
      if (push_n != 2'd0) begin
        pc_d[wr_ptr_q]   = c0_pc;
        inst_d[wr_ptr_q] = c0_inst;
      end
      if (push_n == 2'd2) begin
        pc_d[wr_ptr_p1]   = fetch_inst1_pc_i;
        inst_d[wr_ptr_p1] = fetch_inst1_inst_i;
      end
    end

    if (flush_iq_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + ptr_t'(pop_n);
      wr_ptr_d = wr_ptr_q + ptr_t'(push_n);
      count_d  = count_q + cnt_t'(push_n) - cnt_t'(pop_n);
    end
  end

  // Registered queue state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= pc_d[i];
        inst_q[i] <= inst_d[i];
      end
    end
  end

  // Flag fetch offered while the queue cannot take a pair; the data is dropped.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (fetch_ready_o || !(fetch_inst0_valid_i || fetch_inst1_valid_i))
        else $warning("inst_queue: fetch offered while not ready, dropped");
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: randomized self-checking bench for inst_queue against a
// queue-based reference model of the buffer contents.
module tb_inst_queue;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_iq_i;
  logic        fetch_inst0_valid_i, fetch_inst1_valid_i;
  logic [63:0] fetch_inst0_pc_i, fetch_inst1_pc_i;
  logic [31:0] fetch_inst0_inst_i, fetch_inst1_inst_i;
  logic        fetch_ready_o;
  logic        stall_decoder_inst0_i, stall_decoder_inst1_i;
  logic        inst0_f1_valid_o, inst1_f1_valid_o;
  logic [63:0] inst0_f1_pc_o, inst1_f1_pc_o;
  logic [31:0] inst0_f1_inst_o, inst1_f1_inst_o;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t mq[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .flush_iq_i            (flush_iq_i),
    .fetch_inst0_valid_i   (fetch_inst0_valid_i),
    .fetch_inst1_valid_i   (fetch_inst1_valid_i),
    .fetch_inst0_pc_i      (fetch_inst0_pc_i),
    .fetch_inst1_pc_i      (fetch_inst1_pc_i),
    .fetch_inst0_inst_i    (fetch_inst0_inst_i),
    .fetch_inst1_inst_i    (fetch_inst1_inst_i),
    .fetch_ready_o         (fetch_ready_o),
    .stall_decoder_inst0_i (stall_decoder_inst0_i),
    .stall_decoder_inst1_i (stall_decoder_inst1_i),
    .inst0_f1_valid_o      (inst0_f1_valid_o),
    .inst1_f1_valid_o      (inst1_f1_valid_o),
    .inst0_f1_pc_o         (inst0_f1_pc_o),
    .inst1_f1_pc_o         (inst1_f1_pc_o),
    .inst0_f1_inst_o       (inst0_f1_inst_o),
    .inst1_f1_inst_o       (inst1_f1_inst_o)
  );

  // Expected {ready, v0, entry0, v1, entry1} from the model; absent entries read 0.
  function automatic logic [194:0] exp_vec();
    logic rdy, v0, v1;
    ent_t e0, e1;
    rdy = (int'(DEPTH) - mq.size()) >= 2;
    v0  = mq.size() >= 1;
    v1  = mq.size() >= 2;
    e0  = v0 ? mq[0] : '0;
    e1  = v1 ? mq[1] : '0;
    return {rdy, v0, e0, v1, e1};
  endfunction

  // Observed outputs, with entry data masked where the model holds no entry.
  function automatic logic [194:0] obs_vec();
    ent_t o0, o1;
    o0 = (mq.size() >= 1) ? {inst0_f1_pc_o, inst0_f1_inst_o} : '0;
    o1 = (mq.size() >= 2) ? {inst1_f1_pc_o, inst1_f1_inst_o} : '0;
    return {fetch_ready_o, inst0_f1_valid_o, o0, inst1_f1_valid_o, o1};
  endfunction

  task automatic idle_inputs();
    flush_iq_i            = 1'b0;
    fetch_inst0_valid_i   = 1'b0;
    fetch_inst1_valid_i   = 1'b0;
    fetch_inst0_pc_i      = '0;
    fetch_inst1_pc_i      = '0;
    fetch_inst0_inst_i    = '0;
    fetch_inst1_inst_i    = '0;
    stall_decoder_inst0_i = 1'b0;
    stall_decoder_inst1_i = 1'b0;
  endtask

  // Drive one cycle from a negedge, advance the model, return at the next negedge.
  task automatic cycle(input logic f0v, input logic f1v,
                       input logic [63:0] p0, input logic [31:0] i0,
                       input logic [63:0] p1, input logic [31:0] i1,
                       input logic s0, input logic s1, input logic fl);
    logic rdy;
    int   npop;
    fetch_inst0_valid_i   = f0v;
    fetch_inst1_valid_i   = f1v;
    fetch_inst0_pc_i      = p0;
    fetch_inst0_inst_i    = i0;
    fetch_inst1_pc_i      = p1;
    fetch_inst1_inst_i    = i1;
    stall_decoder_inst0_i = s0;
    stall_decoder_inst1_i = s1;
    flush_iq_i            = fl;
    if (fl) begin
      mq.delete();
    end else begin
      rdy  = (int'(DEPTH) - mq.size()) >= 2;
      npop = (!s0 && !s1) ? ((mq.size() < 2) ? mq.size() : 2) : 0;
      repeat (npop) void'(mq.pop_front());
      if (rdy) begin
        if (f0v) mq.push_back('{pc: p0, inst: i0});
        if (f1v) mq.push_back('{pc: p1, inst: i1});
      end
    end
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    checks++;
    if (fetch_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", fetch_ready_o);
    end
    checks++;
    if ({inst0_f1_valid_o, inst1_f1_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 00", {inst0_f1_valid_o, inst1_f1_valid_o});
    end
    checks++;
    if ({inst0_f1_pc_o, inst0_f1_inst_o, inst1_f1_pc_o, inst1_f1_inst_o} !== 192'd0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0",
               {inst0_f1_pc_o, inst0_f1_inst_o, inst1_f1_pc_o, inst1_f1_inst_o});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    #1;
  endtask

  task automatic test_basic();
    cycle(1, 1, 64'h1000, 32'h13, 64'h1004, 32'h13, 0, 0, 0);
    checks++;
    if (obs_vec() !== exp_vec() || mq.size() != 2) begin
      errors++;
      $display("FAIL basic_latency: got %h expected %h", obs_vec(), exp_vec());
    end
    cycle(0, 0, '0, '0, '0, '0, 0, 0, 0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL basic_drain: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_fill();
    logic [63:0] pc;
    pc = 64'h4000;
    cycle(1, 0, pc, pc[31:0] ^ 32'h5a5a0000, '0, '0, 1, 0, 0);
    pc += 4;
    for (int k = 0; k < 3; k++) begin
      cycle(1, 1, pc, pc[31:0] ^ 32'h5a5a0000, pc + 4, pc[31:0] ^ 32'h5a5a0004, 1, 0, 0);
      pc += 8;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL fill_step%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (fetch_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL fill_ready_at_7: got %b expected 0", fetch_ready_o);
    end
    // Offered at count 7: dropped, model keeps 7 entries.
    cycle(1, 1, 64'hdead0, 32'h1, 64'hdead4, 32'h2, 0, 1, 0);
    checks++;
    if (obs_vec() !== exp_vec() || mq.size() != 7) begin
      errors++;
      $display("FAIL fill_drop: got %h expected %h", obs_vec(), exp_vec());
    end
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, '0, '0, '0, '0, 0, 0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL fill_drain%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_odd_drain();
    cycle(1, 1, 64'h5000, 32'h11, 64'h5004, 32'h22, 1, 1, 0);
    cycle(0, 1, '0, '0, 64'h5008, 32'h33, 1, 1, 0);
    checks++;
    if (obs_vec() !== exp_vec() || mq.size() != 3) begin
      errors++;
      $display("FAIL odd_three: got %h expected %h", obs_vec(), exp_vec());
    end
    for (int k = 0; k < 2; k++) begin
      cycle(0, 0, '0, '0, '0, '0, 0, 0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL odd_pop%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
    end
    // Accept on an empty queue must not underflow.
    cycle(0, 0, '0, '0, '0, '0, 0, 0, 0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL odd_empty_accept: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_flush();
    cycle(1, 1, 64'h6000, 32'h1, 64'h6004, 32'h2, 1, 0, 0);
    cycle(1, 1, 64'h6008, 32'h3, 64'h600c, 32'h4, 1, 0, 0);
    cycle(1, 0, 64'h6010, 32'h5, '0, '0, 1, 0, 0);
    checks++;
    if (obs_vec() !== exp_vec() || mq.size() != 5) begin
      errors++;
      $display("FAIL flush_pre: got %h expected %h", obs_vec(), exp_vec());
    end
    cycle(1, 1, 64'h6014, 32'h6, 64'h6018, 32'h7, 0, 0, 1);
    checks++;
    if ({fetch_ready_o, inst0_f1_valid_o, inst1_f1_valid_o} !== 3'b100) begin
      errors++;
      $display("FAIL flush_empty: got %b expected 100",
               {fetch_ready_o, inst0_f1_valid_o, inst1_f1_valid_o});
    end
    cycle(0, 0, '0, '0, '0, '0, 0, 0, 0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL flush_pair_absent: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_wrap();
    int sent, rcvd, nsend, cyc;
    logic s0, s1, rdy, slot1_only;
    logic [63:0] pa, pb;
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    while ((sent < 40 || mq.size() > 0) && cyc < 600) begin
      cyc++;
      s0    = ($urandom_range(0, 3) == 0);
      s1    = ($urandom_range(0, 4) == 0);
      nsend = $urandom_range(0, 2);
      if (nsend > 40 - sent) nsend = 40 - sent;
      slot1_only = $urandom_range(0, 1) == 1;
      pa  = 64'h2000 + 64'(4 * sent);
      pb  = pa + 4;
      rdy = (int'(DEPTH) - mq.size()) >= 2;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL wrap_state cyc%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
      if (!s0 && !s1 && inst0_f1_valid_o) begin
        checks++;
        if (inst0_f1_pc_o !== 64'h2000 + 64'(4 * rcvd)) begin
          errors++;
          $display("FAIL wrap_order0: got %h expected %h", inst0_f1_pc_o, 64'h2000 + 64'(4 * rcvd));
        end
        rcvd++;
        if (inst1_f1_valid_o) begin
          checks++;
          if (inst1_f1_pc_o !== 64'h2000 + 64'(4 * rcvd)) begin
            errors++;
            $display("FAIL wrap_order1: got %h expected %h", inst1_f1_pc_o, 64'h2000 + 64'(4 * rcvd));
          end
          rcvd++;
        end
      end
      if (nsend == 2)
        cycle(1, 1, pa, pa[31:0] ^ 32'hc0de0000, pb, pb[31:0] ^ 32'hc0de0000, s0, s1, 0);
      else if (nsend == 1 && slot1_only)
        cycle(0, 1, '0, '0, pa, pa[31:0] ^ 32'hc0de0000, s0, s1, 0);
      else if (nsend == 1)
        cycle(1, 0, pa, pa[31:0] ^ 32'hc0de0000, '0, '0, s0, s1, 0);
      else
        cycle(0, 0, '0, '0, '0, '0, s0, s1, 0);
      if (rdy) sent += nsend;
    end
    checks++;
    if (sent != 40 || rcvd != 40 || cyc >= 600) begin
      errors++;
      $display("FAIL wrap_total: got sent=%0d rcvd=%0d cycles=%0d expected 40/40 under 600",
               sent, rcvd, cyc);
    end
  endtask

  task automatic test_reset_midstream();
    cycle(1, 1, 64'h7000, 32'h9, 64'h7004, 32'ha, 1, 0, 0);
    rst_n = 1'b0;
    mq.delete();
    #1;
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL midstream_reset: got %h expected %h", obs_vec(), exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

`ifdef IQ_BYPASS_EN
  task automatic test_bypass();
    fetch_inst0_valid_i = 1'b1;
    fetch_inst0_pc_i    = 64'h3000;
    fetch_inst0_inst_i  = 32'h13;
    #1;
    checks++;
    if ({inst0_f1_valid_o, inst1_f1_valid_o, inst0_f1_pc_o} !== {2'b10, 64'h3000}) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %b%b %h expected 10 3000",
               inst0_f1_valid_o, inst1_f1_valid_o, inst0_f1_pc_o);
    end
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (inst0_f1_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bypass_not_written: got %b expected 0", inst0_f1_valid_o);
    end
    fetch_inst0_valid_i   = 1'b1;
    fetch_inst1_valid_i   = 1'b1;
    fetch_inst0_pc_i      = 64'h3004;
    fetch_inst1_pc_i      = 64'h3008;
    stall_decoder_inst0_i = 1'b1;
    #1;
    checks++;
    if ({inst0_f1_valid_o, inst1_f1_valid_o, inst1_f1_pc_o} !== {2'b11, 64'h3008}) begin
      errors++;
      $display("FAIL bypass_pair: got %b%b %h expected 11 3008",
               inst0_f1_valid_o, inst1_f1_valid_o, inst1_f1_pc_o);
    end
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    stall_decoder_inst0_i = 1'b1;
    #1;
    checks++;
    if ({inst0_f1_valid_o, inst0_f1_pc_o, inst1_f1_pc_o} !== {1'b1, 64'h3004, 64'h3008}) begin
      errors++;
      $display("FAIL bypass_stall_written: got %b %h %h expected 1 3004 3008",
               inst0_f1_valid_o, inst0_f1_pc_o, inst1_f1_pc_o);
    end
    stall_decoder_inst0_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({inst0_f1_valid_o, fetch_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL bypass_drain: got %b expected 01", {inst0_f1_valid_o, fetch_ready_o});
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef IQ_BYPASS_EN
    test_bypass();
    test_reset_midstream();
`else
    test_basic();
    test_fill();
    test_odd_drain();
    test_flush();
    test_wrap();
    test_reset_midstream();
    test_basic();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
